mem_controller: RTL and testbench
=================================

MEM_CONTROLLER -- requirements
Module: mem_controller

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of both request ports and the RAM port.
REQ-002 Port: clk  in  1  system clock; all state updates on rising edge.
REQ-003 Port: nrst  in  1  reset; asynchronous, active-low.
REQ-004 Port: imem_ren  in  1  instruction fetch request; held high until ihit.
REQ-005 Port: imem_addr  in  ADDR_W  fetch byte address; word-aligned.
REQ-006 Port: imem_load  out  32  fetched instruction word; valid while ihit.
REQ-007 Port: ihit  out  1  one-cycle fetch completion pulse.
REQ-008 Port: dmem_ren / dmem_wen  in  1 each  data load / store request; held until dhit.
REQ-009 Port: dmem_addr  in  ADDR_W  data byte address.
REQ-010 Port: dmem_width  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
REQ-011 Port: dmem_store  in  32  store data, right-justified.
REQ-012 Port: dmem_load  out  32  load data, right-justified, zero-padded; valid while dhit.
REQ-013 Port: dhit  out  1  one-cycle data completion pulse.
REQ-014 Port: dmem_misalign  out  1  pulses with dhit when the data access was misaligned.
REQ-015 Port: ram_req, ram_wen  out  1 each  RAM access request and write qualifier.
REQ-016 Port: ram_addr  out  ADDR_W  word address; bits [1:0] are 0.
REQ-017 Port: ram_strb  out  4  byte-lane write enables; ram_wdata  out  32  lane-positioned data.
REQ-018 Port: ram_rdata  in  32  read word; ram_ack  in  1  access complete, sampled while ram_req is high.

Function
REQ-019 FSM states: IDLE, D_ACC, I_ACC, RESP.
REQ-020 IDLE: a data request (dmem_ren or dmem_wen) goes to D_ACC; else imem_ren goes to I_ACC; data has priority when both are pending.
REQ-021 On D_ACC/I_ACC entry, register the address, width, store data and request type; later input changes are ignored until RESP.
REQ-022 D_ACC/I_ACC: ram_req is high and the RAM outputs are stable each cycle until ram_ack; then go to RESP.
REQ-023 On ram_ack, capture the aligned load data into a response register.
REQ-024 RESP: exactly one of ihit/dhit is high for one cycle with imem_load/dmem_load driven from the response register; then go to IDLE.
REQ-025 Minimum request-to-hit latency is 3 cycles: entry edge, ack edge, RESP cycle, with ack on the first access cycle.
REQ-026 Requester deasserts or updates its request in the cycle after the hit; a still-held request is served again.
REQ-027 Load alignment: dmem_load = ram_rdata >> (8*addr[1:0]), masked to the access width; upper bits are 0 (the requester sign-extends).
REQ-028 Store: ram_wdata = the width-sized dmem_store replicated across all lanes; ram_strb is 0001/0011/1111 shifted left by addr[1:0].
REQ-029 Reads drive ram_strb = 0000 and ram_wen = 0.
REQ-030 dmem_ren and dmem_wen both high is serviced as a store.
REQ-031 Misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) goes IDLE to RESP with no RAM access: dhit=1, dmem_misalign=1, dmem_load=0.
REQ-032 imem_addr[1:0] is ignored; fetches are always word reads.

Reset
REQ-033 nrst low forces IDLE, the response register to 0, and all outputs to 0, including mid-access; the RAM access is abandoned.
REQ-034 The first request is accepted on the first rising edge after nrst deasserts.

Structure
REQ-035 mem_width_t (BYTE, HALF, WORD) and memctl_state_t are defined in rv32ima_pkg.
REQ-036 Lane shifting and masking are in the combinational sub-module mem_lane_align; the FSM stays in mem_controller.

Verification
REQ-037 Fetch at 0x100, ram_rdata=0x00000013, ack on the first access cycle -> ram_addr=0x100, ihit on cycle 3, imem_load=0x00000013.
REQ-038 imem_ren and dmem_ren both high at the same edge -> the data access is served first, then the fetch; the dhit pulse precedes the ihit pulse.
REQ-039 SB 0x000000AB at 0x203 -> ram_addr=0x200, ram_strb=1000, ram_wdata=0xABABABAB, ram_wen=1.
REQ-040 LH at 0x202, ram_rdata=0xBEEF1234 -> dmem_load=0x0000BEEF.
REQ-041 LW at 0x201 -> dhit and dmem_misalign in cycle 2, ram_req never high, dmem_load=0.
REQ-042 nrst pulsed low while D_ACC waits with ack held low -> ram_req drops immediately, the FSM is in IDLE, no hit pulse appears.

Source files
------------

// File: rtl/rv32ima_pkg.sv
// Shared types for the memory controller: access widths, FSM states and
// small decode helpers used by both the controller and the lane aligner.
package rv32ima_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        D_ACC = 2'b01,
        I_ACC = 2'b10,
        RESP  = 2'b11
    } memctl_state_t;

    // The unused encoding 2'b11 behaves as a full word access.
    function automatic mem_width_t decode_width(input logic [1:0] w);
        case (w)
            2'b00:   return BYTE;
            2'b01:   return HALF;
            default: return WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_width_t w, input logic [1:0] lo);
        case (w)
            HALF:    return lo[0];
            WORD:    return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Purely combinational byte-lane steering: store data replication and
// strobes toward the RAM, and right-justified zero-padded load data back.
module mem_lane_align
    import rv32ima_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  mem_width_t  width,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  strb,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr_lo, 3'b000};

    always_comb begin
        wdata     = store_data;
        strb      = 4'b1111;
        load_data = shifted;
        case (width)
            BYTE: begin
                wdata     = {4{store_data[7:0]}};
                strb      = 4'b0001 << addr_lo;
                load_data = {24'h0, shifted[7:0]};
            end
            HALF: begin
                wdata     = {2{store_data[15:0]}};
                strb      = 4'b0011 << addr_lo;
                load_data = {16'h0, shifted[15:0]};
            end
            default: begin
                wdata     = store_data;
                strb      = 4'b1111;
                load_data = shifted;
            end
        endcase
    end

endmodule

// File: rtl/mem_controller.sv
// Arbitrates one instruction port and one data port onto a single-word RAM
// port; data wins ties, misaligned data accesses complete without RAM access.
module mem_controller
    import rv32ima_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              imem_ren,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_load,
    output logic              ihit,
    input  logic              dmem_ren,
    input  logic              dmem_wen,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [1:0]        dmem_width,
    input  logic [31:0]       dmem_store,
    output logic [31:0]       dmem_load,
    output logic              dhit,
    output logic              dmem_misalign,
    output logic              ram_req,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_strb,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata,
    input  logic              ram_ack
);

    memctl_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_width_t        width_q, width_d;
    logic [31:0]       store_q, store_d;
    logic              wr_q, wr_d;
    logic              is_data_q, is_data_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       resp_q, resp_d;

    logic [1:0]        lane_lo;
    logic [31:0]       al_wdata;
    logic [3:0]        al_strb;
    logic [31:0]       al_load;
    mem_width_t        req_width;

    // Fetches are always aligned word reads regardless of the low address bits.
    assign lane_lo   = is_data_q ? addr_q[1:0] : 2'b00;
    assign req_width = decode_width(dmem_width);

    mem_lane_align u_align (
        .addr_lo    (lane_lo),
        .width      (width_q),
        .store_data (store_q),
        .rdata      (ram_rdata),
        .wdata      (al_wdata),
        .strb       (al_strb),
        .load_data  (al_load)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            width_q    <= WORD;
            store_q    <= '0;
            wr_q       <= 1'b0;
            is_data_q  <= 1'b0;
            misalign_q <= 1'b0;
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            width_q    <= width_d;
            store_q    <= store_d;
            wr_q       <= wr_d;
            is_data_q  <= is_data_d;
            misalign_q <= misalign_d;
            resp_q     <= resp_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        width_d    = width_q;
        store_d    = store_q;
        wr_d       = wr_q;
        is_data_d  = is_data_q;
        misalign_d = misalign_q;
        resp_d     = resp_q;
        case (state_q)
            IDLE: begin
                if (dmem_ren || dmem_wen) begin
                    addr_d    = dmem_addr;
                    width_d   = req_width;
                    store_d   = dmem_store;
                    wr_d      = dmem_wen;
                    is_data_d = 1'b1;
                    if (is_misaligned(req_width, dmem_addr[1:0])) begin
                        misalign_d = 1'b1;
                        resp_d     = '0;
                        state_d    = RESP;
                    end else begin
                        misalign_d = 1'b0;
                        state_d    = D_ACC;
                    end
                end else if (imem_ren) begin
                    addr_d     = imem_addr;
                    width_d    = WORD;
                    wr_d       = 1'b0;
                    is_data_d  = 1'b0;
                    misalign_d = 1'b0;
                    state_d    = I_ACC;
                end
            end
            D_ACC, I_ACC: begin
                if (ram_ack) begin
                    resp_d  = wr_q ? 32'h0 : al_load;
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ram_req       = (state_q == D_ACC) || (state_q == I_ACC);
    assign ram_wen       = ram_req && wr_q;
    assign ram_addr      = {addr_q[ADDR_W-1:2], 2'b00};
    assign ram_strb      = ram_wen ? al_strb : 4'b0000;
    assign ram_wdata     = ram_wen ? al_wdata : 32'h0;
    assign ihit          = (state_q == RESP) && !is_data_q;
    assign dhit          = (state_q == RESP) && is_data_q;
    assign dmem_misalign = dhit && misalign_q;
    assign imem_load     = ihit ? resp_q : 32'h0;
    assign dmem_load     = dhit ? resp_q : 32'h0;

endmodule

// File: tb/tb_mem_controller.sv
// Self-checking bench: table of data accesses with a hit scoreboard, plus
// hand-written fetch, priority and mid-access reset sequences.
module tb_mem_controller;
    import rv32ima_pkg::*;

    logic        clk = 1'b0;
    logic        nrst;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_load;
    logic        ihit;
    logic        dmem_ren, dmem_wen;
    logic [31:0] dmem_addr;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_store;
    logic [31:0] dmem_load;
    logic        dhit, dmem_misalign;
    logic        ram_req, ram_wen;
    logic [31:0] ram_addr;
    logic [3:0]  ram_strb;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_controller #(.ADDR_W(32)) dut (
        .clk(clk), .nrst(nrst),
        .imem_ren(imem_ren), .imem_addr(imem_addr), .imem_load(imem_load), .ihit(ihit),
        .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
        .dmem_width(dmem_width), .dmem_store(dmem_store), .dmem_load(dmem_load),
        .dhit(dhit), .dmem_misalign(dmem_misalign),
        .ram_req(ram_req), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_strb(ram_strb),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    typedef struct {
        logic        is_data;
        logic [31:0] load;
        logic        chk_load;
        logic        misalign;
    } exp_t;

    typedef struct {
        logic        ren;
        logic        wen;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] store;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_load;
        logic        exp_mis;
    } vec_t;

    exp_t sb[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Hit monitor: every hit pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (nrst && (ihit || dhit)) begin
            exp_t e;
            check32("single_hit", {31'h0, ihit && dhit}, 32'h0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit: got ihit=%0b dhit=%0b required none", ihit, dhit);
            end else begin
                e = sb.pop_front();
                check32("hit_kind", {31'h0, dhit}, {31'h0, e.is_data});
                if (e.is_data) begin
                    if (e.chk_load) check32("dmem_load", dmem_load, e.load);
                    check32("dmem_misalign", {31'h0, dmem_misalign}, {31'h0, e.misalign});
                end else begin
                    check32("imem_load", imem_load, e.load);
                end
                $display("hit %s load=%h misalign=%0b", dhit ? "data" : "inst",
                         dhit ? dmem_load : imem_load, dmem_misalign);
            end
        end
    end

    task automatic run_data(input vec_t v);
        exp_t e;
        int   lat = 0;
        bit   acked = 0;
        bit   done = 0;
        dmem_ren   = v.ren;
        dmem_wen   = v.wen;
        dmem_addr  = v.addr;
        dmem_width = v.width;
        dmem_store = v.store;
        e.is_data  = 1'b1;
        e.load     = v.exp_load;
        e.chk_load = !v.wen || v.exp_mis;
        e.misalign = v.exp_mis;
        sb.push_back(e);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (ram_ack) ram_ack = 1'b0;
            if (ram_req && !acked) begin
                check32("ram_addr", ram_addr, v.exp_addr);
                check32("ram_strb", {28'h0, ram_strb}, {28'h0, v.exp_strb});
                check32("ram_wen", {31'h0, ram_wen}, {31'h0, v.wen});
                if (v.wen) check32("ram_wdata", ram_wdata, v.exp_wdata);
                ram_rdata = v.rdata;
                ram_ack   = 1'b1;
                acked     = 1'b1;
            end
            if (dhit) done = 1'b1;
        end
        check32("data_done", {31'h0, done}, 32'h1);
        check32("data_latency", lat, v.exp_mis ? 1 : 2);
        check32("ram_used", {31'h0, acked}, {31'h0, !v.exp_mis});
        $display("data ren=%0b wen=%0b w=%0d addr=%h latency=%0d", v.ren, v.wen, v.width, v.addr, lat);
        dmem_ren = 1'b0;
        dmem_wen = 1'b0;
        ram_ack  = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_fetch(input logic [31:0] addr, input logic [31:0] rdata,
                             input logic [31:0] exp_addr, input int ack_delay);
        exp_t e;
        int   lat = 0;
        int   waited = 0;
        bit   done = 0;
        imem_ren  = 1'b1;
        imem_addr = addr;
        e.is_data = 1'b0;
        e.load = rdata;
        e.chk_load = 1'b1;
        e.misalign = 1'b0;
        sb.push_back(e);
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (ram_ack) ram_ack = 1'b0;
            if (ram_req && !ram_ack) begin
                check32("fetch_ram_addr", ram_addr, exp_addr);
                check32("fetch_ram_wen", {31'h0, ram_wen}, 32'h0);
                imem_addr = 32'hFFFF_FFF0;  // address changes after entry must be ignored
                if (waited == ack_delay) begin
                    ram_rdata = rdata;
                    ram_ack   = 1'b1;
                end
                waited++;
            end
            if (ihit) done = 1'b1;
        end
        check32("fetch_done", {31'h0, done}, 32'h1);
        check32("fetch_latency", lat, 2 + ack_delay);
        $display("fetch addr=%h latency=%0d", addr, lat);
        imem_ren = 1'b0;
        ram_ack  = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[10];

    initial begin
        // ren wen width addr store rdata exp_addr strb wdata load mis
        vecs[0] = '{0, 1, 2'b00, 32'h203, 32'h0000_00AB, 32'h0, 32'h200, 4'b1000, 32'hABAB_ABAB, 32'h0, 0};
        vecs[1] = '{1, 0, 2'b01, 32'h202, 32'h0, 32'hBEEF_1234, 32'h200, 4'b0000, 32'h0, 32'h0000_BEEF, 0};
        vecs[2] = '{1, 0, 2'b00, 32'h201, 32'h0, 32'h1122_3344, 32'h200, 4'b0000, 32'h0, 32'h0000_0033, 0};
        vecs[3] = '{1, 0, 2'b10, 32'h204, 32'h0, 32'hDEAD_BEEF, 32'h204, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0};
        vecs[4] = '{0, 1, 2'b01, 32'h102, 32'h1234_5678, 32'h0, 32'h100, 4'b1100, 32'h5678_5678, 32'h0, 0};
        vecs[5] = '{0, 1, 2'b11, 32'h300, 32'hCAFE_F00D, 32'h0, 32'h300, 4'b1111, 32'hCAFE_F00D, 32'h0, 0};
        vecs[6] = '{1, 0, 2'b10, 32'h201, 32'h0, 32'hFFFF_FFFF, 32'h0, 4'b0000, 32'h0, 32'h0, 1};
        vecs[7] = '{0, 1, 2'b01, 32'h105, 32'h0000_BBBB, 32'hFFFF_FFFF, 32'h0, 4'b0000, 32'h0, 32'h0, 1};
        vecs[8] = '{1, 1, 2'b00, 32'h000, 32'h0000_005A, 32'h0, 32'h000, 4'b0001, 32'h5A5A_5A5A, 32'h0, 0};
        vecs[9] = '{1, 0, 2'b00, 32'h003, 32'h0, 32'h8000_0000, 32'h000, 4'b0000, 32'h0, 32'h0000_0080, 0};

        nrst = 1'b0;
        imem_ren = 0; imem_addr = 0;
        dmem_ren = 0; dmem_wen = 0; dmem_addr = 0; dmem_width = 0; dmem_store = 0;
        ram_rdata = 0; ram_ack = 0;
        @(negedge clk);
        @(negedge clk);
        check32("rst_ram", {ram_req, ram_wen, ram_strb}, 6'h0);
        check32("rst_ram_addr", ram_addr, 32'h0);
        check32("rst_ram_wdata", ram_wdata, 32'h0);
        check32("rst_hits", {ihit, dhit, dmem_misalign}, 3'h0);
        check32("rst_loads", imem_load | dmem_load, 32'h0);

        // Request presented right as reset releases is taken on the first edge.
        nrst = 1'b1;
        run_fetch(32'h100, 32'h0000_0013, 32'h100, 0);
        run_fetch(32'h10E, 32'hAABB_CCDD, 32'h10C, 2);

        for (int i = 0; i < 10; i++) run_data(vecs[i]);

        // Simultaneous fetch and load: data first, then fetch.
        begin
            exp_t e;
            int   lat = 0;
            int   nacc = 0;
            imem_ren = 1; imem_addr = 32'h400;
            dmem_ren = 1; dmem_wen = 0; dmem_addr = 32'h500; dmem_width = 2'b10;
            e = '{1'b1, 32'h5555_0000, 1'b1, 1'b0}; sb.push_back(e);
            e = '{1'b0, 32'h4444_0000, 1'b1, 1'b0}; sb.push_back(e);
            while ((imem_ren || dmem_ren) && lat < 30) begin
                @(negedge clk);
                lat++;
                if (ram_ack) ram_ack = 1'b0;
                else if (ram_req) begin
                    check32("prio_addr", ram_addr, nacc == 0 ? 32'h500 : 32'h400);
                    ram_rdata = (nacc == 0) ? 32'h5555_0000 : 32'h4444_0000;
                    ram_ack = 1'b1;
                    nacc++;
                end
                if (dhit) dmem_ren = 1'b0;
                if (ihit) imem_ren = 1'b0;
            end
            check32("prio_both_served", {30'h0, imem_ren, dmem_ren}, 32'h0);
            check32("prio_accesses", nacc, 2);
            $display("priority sequence done after %0d cycles", lat);
            ram_ack = 1'b0;
            @(negedge clk);
        end

        // Reset while the RAM never acks: access abandoned, no hit.
        begin
            int lat = 0;
            dmem_ren = 1; dmem_wen = 0; dmem_addr = 32'h40; dmem_width = 2'b10;
            while (!ram_req && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            check32("rst_mid_req_seen", {31'h0, ram_req}, 32'h1);
            #2 nrst = 1'b0;
            #1;
            check32("rst_mid_ram_req", {31'h0, ram_req}, 32'h0);
            check32("rst_mid_state", {30'h0, dut.state_q}, {30'h0, IDLE});
            dmem_ren = 1'b0;
            @(negedge clk);
            nrst = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                check32("rst_mid_quiet", {30'h0, ram_req, dhit}, 32'h0);
            end
            $display("mid-access reset sequence done");
        end

        check32("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
